// File: rtl/regfile_operand_sequencer_pkg.sv
// Shared definitions for the operand sequencer: widths and FSM state encodings.
package regfile_operand_sequencer_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_VALID = 2'd2
  } seq_state_t;

endpackage

// File: rtl/regfile_operand_sequencer_scoreboard.sv
// Busy scoreboard: one bit per register, set has priority over clear on the same bit,
// two combinational lookup ports for the hazard check.
module reg_scoreboard
  import regfile_operand_sequencer_pkg::*;
#(
  parameter int SB_ADDR_W = ADDR_W,
  parameter int SB_NREG   = NREG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [SB_ADDR_W-1:0] set_addr,
  input  logic                 clr_en,
  input  logic [SB_ADDR_W-1:0] clr_addr,
  input  logic [SB_ADDR_W-1:0] lookup_a,
  input  logic [SB_ADDR_W-1:0] lookup_b,
  output logic                 busy_a,
  output logic                 busy_b,
  output logic [SB_NREG-1:0]   busy
);

  // Per-bit update; an issuing instruction claiming a register outranks a writeback releasing it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < SB_NREG; i++) begin
        if (set_en && (set_addr == SB_ADDR_W'(i)))
          busy[i] <= 1'b1;
        else if (clr_en && (clr_addr == SB_ADDR_W'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

  // Combinational lookups for the two source operands
  always_comb begin
    busy_a = busy[lookup_a];
    busy_b = busy[lookup_b];
  end

endmodule

// File: rtl/regfile_operand_sequencer.sv
// Operand sequencer: accepts one decoded instruction, checks RAW hazards against the busy
// scoreboard, captures (forwarded) operands for the ALU, and registers the writeback port.
module regfile_operand_sequencer
  import regfile_operand_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_rd_wen,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_rd,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] rf_aaddr,
  output logic [ADDR_W-1:0] rf_baddr,
  input  logic [DATA_W-1:0] rf_adata,
  input  logic [DATA_W-1:0] rf_bdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREG-1:0]   busy
);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] rd_q;
  logic              rd_wen_q;
  logic              busy_a, busy_b;
  logic              hazard;
  logic              capture;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  assign hazard  = busy_a | busy_b;
  assign capture = (state == ST_CHECK) && !hazard;

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (capture && rd_wen_q),
    .set_addr (rd_q),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .lookup_a (rf_aaddr),
    .lookup_b (rf_baddr),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .busy     (busy)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: stall in CHECK while either source is still busy
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (issue_valid) state_nxt = ST_CHECK;
      ST_CHECK: if (!hazard)     state_nxt = ST_VALID;
      ST_VALID: if (op_ready)    state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    issue_ready = (state == ST_IDLE);
    op_valid    = (state == ST_VALID);
  end

  // Forwarding: the register file writes on the falling edge, so bypass the pending write
  always_comb begin
    fwd_a = (rf_we && (rf_waddr == rf_aaddr)) ? rf_wdata : rf_adata;
    fwd_b = (rf_we && (rf_waddr == rf_baddr)) ? rf_wdata : rf_bdata;
  end

  // Instruction latch on accept and operand capture on leaving CHECK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_aaddr <= '0;
      rf_baddr <= '0;
      rd_q     <= '0;
      rd_wen_q <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_rd    <= '0;
    end else begin
      if ((state == ST_IDLE) && issue_valid) begin
        rf_aaddr <= issue_rs1;
        rf_baddr <= issue_rs2;
        rd_q     <= issue_rd;
        rd_wen_q <= issue_rd_wen;
      end
      if (capture) begin
        op_a  <= fwd_a;
        op_b  <= fwd_b;
        op_rd <= rd_q;
      end
    end
  end

  // Writeback port registers; rf_we follows wb_valid one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wb_valid;
      if (wb_valid) begin
        rf_waddr <= wb_addr;
        rf_wdata <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_operand_sequencer.sv
// Directed bench for regfile_operand_sequencer with a behavioural 8x16 register file
// written on the falling clock edge.
module tb_regfile_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [2:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_rd_wen;
  logic        op_valid, op_ready;
  logic [15:0] op_a, op_b;
  logic [2:0]  op_rd;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  rf_aaddr, rf_baddr;
  logic [15:0] rf_adata, rf_bdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [7:0]  busy;

  logic [15:0] rf_mem [8];
  logic        rf_hold = 1'b0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // Register file model: write on falling edge, combinational reads
  always @(negedge clk) if (rf_we && !rf_hold) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_adata = rf_mem[rf_aaddr];
  assign rf_bdata = rf_mem[rf_baddr];

  regfile_operand_sequencer dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_rd_wen(issue_rd_wen),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_aaddr(rf_aaddr), .rf_baddr(rf_baddr),
    .rf_adata(rf_adata), .rf_bdata(rf_bdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input logic wen);
    issue_valid  = 1'b1;
    issue_rs1    = rs1;
    issue_rs2    = rs2;
    issue_rd     = rd;
    issue_rd_wen = wen;
    tick();
    issue_valid  = 1'b0;
  endtask

  task automatic wb(input logic [2:0] addr, input logic [15:0] data);
    wb_valid = 1'b1;
    wb_addr  = addr;
    wb_data  = data;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic consume();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got=%b exp=1", issue_ready); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got=%b exp=0", op_valid); end
    checks++; if ({op_a, op_b, op_rd, rf_aaddr, rf_baddr} !== '0) begin errors++; $display("FAIL reset_regs got a=%h b=%h rd=%0d aa=%0d ba=%0d exp zeros", op_a, op_b, op_rd, rf_aaddr, rf_baddr); end
    checks++; if ({rf_we, rf_waddr, rf_wdata, busy} !== '0) begin errors++; $display("FAIL reset_wport got we=%b wa=%0d wd=%h busy=%b exp zeros", rf_we, rf_waddr, rf_wdata, busy); end
    rst = 1'b0;
    tick();
    // Make r6 busy, then check reset clears the scoreboard
    issue(3'd0, 3'd0, 3'd6, 1'b1);
    tick();
    consume();
    checks++; if (busy !== 8'b0100_0000) begin errors++; $display("FAIL pre_reset_busy got=%b exp=01000000", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL reset_busy_clear got=%b exp=00000000", busy); end
    checks++; if (issue_ready !== 1'b1 || op_valid !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL reset_handshake got ir=%b ov=%b we=%b exp 1 0 0", issue_ready, op_valid, rf_we); end
    tick();
  endtask

  task automatic test_basic_issue();
    wb(3'd2, 16'h1234);
    wb(3'd3, 16'h00FF);
    tick();
    issue(3'd2, 3'd3, 3'd4, 1'b1);
    checks++; if (op_valid !== 1'b0 || issue_ready !== 1'b0) begin errors++; $display("FAIL basic_check_state got ov=%b ir=%b exp 0 0", op_valid, issue_ready); end
    checks++; if (rf_aaddr !== 3'd2 || rf_baddr !== 3'd3) begin errors++; $display("FAIL basic_raddr got a=%0d b=%0d exp 2 3", rf_aaddr, rf_baddr); end
    tick();
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL basic_op_valid got=%b exp=1", op_valid); end
    checks++; if (op_a !== 16'h1234 || op_b !== 16'h00FF || op_rd !== 3'd4) begin errors++; $display("FAIL basic_operands got a=%h b=%h rd=%0d exp 1234 00ff 4", op_a, op_b, op_rd); end
    checks++; if (busy !== 8'b0001_0000) begin errors++; $display("FAIL basic_busy got=%b exp=00010000", busy); end
    tick();
    checks++; if (op_valid !== 1'b1 || op_a !== 16'h1234) begin errors++; $display("FAIL basic_hold got ov=%b a=%h exp 1 1234", op_valid, op_a); end
    consume();
    checks++; if (op_valid !== 1'b0 || issue_ready !== 1'b1) begin errors++; $display("FAIL basic_consume got ov=%b ir=%b exp 0 1", op_valid, issue_ready); end
  endtask

  task automatic test_stall_forward();
    // Model file ignores this write, so op_a can only come from the bypass
    rf_hold = 1'b1;
    issue(3'd4, 3'd2, 3'd7, 1'b0);
    tick();
    tick();
    checks++; if (op_valid !== 1'b0 || issue_ready !== 1'b0) begin errors++; $display("FAIL stall_hold got ov=%b ir=%b exp 0 0", op_valid, issue_ready); end
    wb(3'd4, 16'hBEEF);
    checks++; if (busy !== 8'h00 || op_valid !== 1'b0) begin errors++; $display("FAIL stall_clear got busy=%b ov=%b exp 00000000 0", busy, op_valid); end
    tick();
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", op_valid); end
    checks++; if (op_a !== 16'hBEEF || op_b !== 16'h1234) begin errors++; $display("FAIL stall_forward got a=%h b=%h exp beef 1234", op_a, op_b); end
    consume();
    rf_hold = 1'b0;
  endtask

  task automatic test_self_dep();
    wb(3'd1, 16'h0A0A);
    tick();
    issue(3'd1, 3'd1, 3'd1, 1'b1);
    tick();
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL selfdep_no_stall got=%b exp=1", op_valid); end
    checks++; if (op_a !== 16'h0A0A || op_b !== 16'h0A0A) begin errors++; $display("FAIL selfdep_operands got a=%h b=%h exp 0a0a 0a0a", op_a, op_b); end
    checks++; if (busy !== 8'b0000_0010) begin errors++; $display("FAIL selfdep_busy got=%b exp=00000010", busy); end
    consume();
  endtask

  task automatic test_set_priority();
    issue(3'd2, 3'd3, 3'd5, 1'b1);
    wb(3'd5, 16'h5555);
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL setprio_valid got=%b exp=1", op_valid); end
    checks++; if (busy !== 8'b0010_0010) begin errors++; $display("FAIL setprio_busy got=%b exp=00100010", busy); end
  endtask

  task automatic test_async_reset();
    // Still in VALID with op_ready low and rf_we high from the previous writeback
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL areset_pre_we got=%b exp=1", rf_we); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (op_valid !== 1'b0 || issue_ready !== 1'b1) begin errors++; $display("FAIL areset_state got ov=%b ir=%b exp 0 1", op_valid, issue_ready); end
    checks++; if (busy !== 8'h00 || rf_we !== 1'b0) begin errors++; $display("FAIL areset_busy got busy=%b we=%b exp 00000000 0", busy, rf_we); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back_wb();
    issue(3'd0, 3'd0, 3'd6, 1'b1);
    tick();
    consume();
    wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 16'h6666;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd6 || rf_wdata !== 16'h6666) begin errors++; $display("FAIL b2b_first got we=%b wa=%0d wd=%h exp 1 6 6666", rf_we, rf_waddr, rf_wdata); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL b2b_busy_clear got=%b exp=00000000", busy); end
    wb_addr = 3'd7; wb_data = 16'h7777;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd7 || rf_wdata !== 16'h7777) begin errors++; $display("FAIL b2b_second got we=%b wa=%0d wd=%h exp 1 7 7777", rf_we, rf_waddr, rf_wdata); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL b2b_nonbusy got=%b exp=00000000", busy); end
    wb_valid = 1'b0;
    tick();
    checks++; if (rf_we !== 1'b0 || rf_wdata !== 16'h7777) begin errors++; $display("FAIL b2b_pulse_end got we=%b wd=%h exp 0 7777", rf_we, rf_wdata); end
    checks++; if (rf_mem[6] !== 16'h6666 || rf_mem[7] !== 16'h7777) begin errors++; $display("FAIL b2b_rf_write got r6=%h r7=%h exp 6666 7777", rf_mem[6], rf_mem[7]); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf_mem[i] = 16'h0000;
    rst = 1'b1;
    issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_rd_wen = 1'b0;
    op_ready = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    test_reset();
    test_basic_issue();
    test_stall_forward();
    test_self_dep();
    test_set_priority();
    test_async_reset();
    test_back_to_back_wb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
